// File: rtl/cpu_seq_pkg.sv
// Shared types for the ALU instruction sequencer: opcodes, FSM states and op classes.
// HOLD only exists when SEQ_SINGLE_STEP_EN is defined.
package cpu_seq_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_ROL = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, TRAP
`ifdef SEQ_SINGLE_STEP_EN
    , HOLD
`endif
  } state_t;

  typedef enum logic [1:0] {BIN, MULDIV, UNARY, ILLEGAL} op_class_t;

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Control bundle between the sequencer (master) and the CPU datapath (slave).
// Widths must match the parameters of the attached sequencer.
interface alu_instr_sequencer_if #(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5,
  parameter int DATA_W   = 32
);
  logic                run;
  logic                mem_ready;
  logic [DATA_W-1:0]   ir;
  logic                pc_out, mdr_out, zlo_out, zhi_out;
  logic                mar_in, pc_in, mdr_in, ir_in, y_in, zlo_in, zhi_in, hi_in, lo_in;
  logic                mdr_read, inc_pc;
  logic [NUM_REGS-1:0] r_out;
  logic [NUM_REGS-1:0] r_in;
  logic [OP_W-1:0]     alu_op;
  logic                busy, done, illegal;

  modport master (
    input  run, mem_ready, ir,
    output pc_out, mdr_out, zlo_out, zhi_out,
    output mar_in, pc_in, mdr_in, ir_in, y_in, zlo_in, zhi_in, hi_in, lo_in,
    output mdr_read, inc_pc, r_out, r_in, alu_op, busy, done, illegal
  );

  modport slave (
    output run, mem_ready, ir,
    input  pc_out, mdr_out, zlo_out, zhi_out,
    input  mar_in, pc_in, mdr_in, ir_in, y_in, zlo_in, zhi_in, hi_in, lo_in,
    input  mdr_read, inc_pc, r_out, r_in, alu_op, busy, done, illegal
  );
endinterface

// File: rtl/seq_decode.sv
// Combinational opcode classifier; any register index outside the register file
// makes the instruction illegal regardless of opcode.
module seq_decode
  import cpu_seq_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int OP_W      = 5
) (
  input  logic [OP_W-1:0]      op,
  input  logic [REG_IDX_W-1:0] ra,
  input  logic [REG_IDX_W-1:0] rb,
  input  logic [REG_IDX_W-1:0] rc,
  output op_class_t            op_class
);

  logic idx_ok;

  always_comb begin
    idx_ok = (int'(ra) < NUM_REGS) && (int'(rb) < NUM_REGS) && (int'(rc) < NUM_REGS);
    op_class = ILLEGAL;
    if (idx_ok) begin
      if ((op >= OP_W'(OP_ADD) && op <= OP_W'(OP_ROL)) ||
          op == OP_W'(OP_AND) || op == OP_W'(OP_OR))
        op_class = BIN;
      else if (op == OP_W'(OP_MUL) || op == OP_W'(OP_DIV))
        op_class = MULDIV;
      else if (op == OP_W'(OP_NEG) || op == OP_W'(OP_NOT))
        op_class = UNARY;
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control FSM for register-register ALU ops; Moore strobes except pc_in in T1.
// SEQ_SINGLE_STEP_EN adds a step input and a HOLD state after each completed instruction.
module alu_instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int OP_W      = 5,
  parameter int DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                  step,
`endif
  alu_instr_sequencer_if.master bus
);

  localparam int RA_MSB = DATA_W - OP_W - 1;
  localparam int RB_MSB = RA_MSB - REG_IDX_W;
  localparam int RC_MSB = RB_MSB - REG_IDX_W;
  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  state_t                 state_q, state_d, done_next;
  op_class_t              cls;
  logic [OP_W-1:0]        op;
  logic [REG_IDX_W-1:0]   ra, rb, rc;
  logic [NUM_REGS-1:0]    oh_ra, oh_rb, oh_rc;
  logic                   illegal_q;
  logic                   unused_ir_low;

  assign op  = bus.ir[DATA_W-1 -: OP_W];
  assign ra  = bus.ir[RA_MSB -: REG_IDX_W];
  assign rb  = bus.ir[RB_MSB -: REG_IDX_W];
  assign rc  = bus.ir[RC_MSB -: REG_IDX_W];
  assign unused_ir_low = &{1'b0, bus.ir[RC_MSB-REG_IDX_W:0]};

  assign oh_ra = ONE << ra;
  assign oh_rb = ONE << rb;
  assign oh_rc = ONE << rc;

  seq_decode #(
    .NUM_REGS  (NUM_REGS),
    .REG_IDX_W (REG_IDX_W),
    .OP_W      (OP_W)
  ) u_decode (
    .op       (op),
    .ra       (ra),
    .rb       (rb),
    .rc       (rc),
    .op_class (cls)
  );

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q, step_rise_q;

  // Registered rise so HOLD leaves one cycle after the edge is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q      <= 1'b0;
      step_rise_q <= 1'b0;
    end else begin
      step_q      <= step;
      step_rise_q <= step & ~step_q;
    end
  end

  assign done_next = HOLD;
`else
  assign done_next = bus.run ? T0 : IDLE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == T3 && cls == ILLEGAL)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.run) state_d = T0;
      T0:      state_d = T1;
      T1:      if (bus.mem_ready) state_d = T2;
      T2:      state_d = T3;
      T3:      state_d = (cls == ILLEGAL) ? TRAP : T4;
      T4:      state_d = T5;
      T5:      state_d = (cls == MULDIV) ? T6 : done_next;
      T6:      state_d = done_next;
      TRAP:    state_d = TRAP;
`ifdef SEQ_SINGLE_STEP_EN
      HOLD:    if (step_rise_q) state_d = bus.run ? T0 : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.pc_out   = 1'b0;
    bus.mdr_out  = 1'b0;
    bus.zlo_out  = 1'b0;
    bus.zhi_out  = 1'b0;
    bus.mar_in   = 1'b0;
    bus.pc_in    = 1'b0;
    bus.mdr_in   = 1'b0;
    bus.ir_in    = 1'b0;
    bus.y_in     = 1'b0;
    bus.zlo_in   = 1'b0;
    bus.zhi_in   = 1'b0;
    bus.hi_in    = 1'b0;
    bus.lo_in    = 1'b0;
    bus.mdr_read = 1'b0;
    bus.inc_pc   = 1'b0;
    bus.r_out    = '0;
    bus.r_in     = '0;
    bus.alu_op   = '0;
    bus.done     = 1'b0;
    bus.busy     = (state_q != IDLE);
    case (state_q)
      T0: begin
        bus.pc_out = 1'b1;
        bus.mar_in = 1'b1;
        bus.inc_pc = 1'b1;
        bus.zlo_in = 1'b1;
      end
      T1: begin
        bus.zlo_out  = 1'b1;
        bus.pc_in    = bus.mem_ready;
        bus.mdr_read = 1'b1;
        bus.mdr_in   = 1'b1;
      end
      T2: begin
        bus.mdr_out = 1'b1;
        bus.ir_in   = 1'b1;
      end
      T3: begin
        if (cls == BIN || cls == MULDIV) begin
          bus.r_out = oh_rb;
          bus.y_in  = 1'b1;
        end
      end
      T4: begin
        if (cls != ILLEGAL) begin
          bus.r_out  = (cls == UNARY) ? oh_rb : oh_rc;
          bus.alu_op = op;
          bus.zlo_in = 1'b1;
          bus.zhi_in = 1'b1;
        end
      end
      T5: begin
        bus.zlo_out = 1'b1;
        if (cls == MULDIV) begin
          bus.lo_in = 1'b1;
        end else begin
          bus.r_in = oh_ra;
          bus.done = 1'b1;
        end
      end
      T6: begin
        bus.zhi_out = 1'b1;
        bus.hi_in   = 1'b1;
        bus.done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.illegal = illegal_q;

endmodule
